// File: rtl/regfile_pkg.sv
// Shared defaults and types for the dual-read register file.
// Holds width/depth defaults, the zero address and the output buffer state.
package regfile_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_DEPTH  = 32;
  localparam int DEF_ADDR_W = 5;

  localparam logic [DEF_ADDR_W-1:0] ZERO_ADDR = '0;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } obuf_state_e;

endpackage

// File: rtl/regfile_word.sv
// One storage word with write enable and async active-low clear.
// Ports: clk, i_rst_n, i_we, i_d[WIDTH], o_q[WIDTH].
import regfile_pkg::*;

module regfile_word #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_we,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else if (i_we) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/regfile_read2.sv
// 32x32 register file with two-operand registered read response
// (valid/ready). Ports: clk, reset_n, wr_en/wr_addr/wr_data,
// req_valid/req_ready/req_addr_a/req_addr_b,
// rsp_valid/rsp_ready/rsp_data_a/rsp_data_b.
// Option: define REGFILE_BYPASS_EN to forward same-edge write data.
import regfile_pkg::*;

module regfile_read2 #(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr_a,
  input  logic [ADDR_W-1:0] req_addr_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WIDTH-1:0]  rsp_data_a,
  output logic [WIDTH-1:0]  rsp_data_b
);

  localparam logic [ADDR_W-1:0] ZA = ADDR_W'(ZERO_ADDR);

  logic [WIDTH-1:0] w_word [DEPTH];
  logic [DEPTH-1:1] w_we;
  logic             w_wr_ok;
  logic [WIDTH-1:0] w_rd_a;
  logic [WIDTH-1:0] w_rd_b;
  logic             w_accept;

  obuf_state_e r_state;
  obuf_state_e w_state_nxt;
  logic [WIDTH-1:0] r_data_a;
  logic [WIDTH-1:0] r_data_b;

  // Word 0 is hardwired; it has no storage.
  assign w_word[0] = '0;

  assign w_wr_ok = wr_en
                && (wr_addr != ZA)
                && (32'(wr_addr) < DEPTH);

  always_comb begin
    w_we = '0;
    for (int i = 1; i < DEPTH; i++) begin
      w_we[i] = w_wr_ok && (wr_addr == ADDR_W'(i));
    end
  end

  for (genvar g = 1; g < DEPTH; g++) begin : g_word
    regfile_word #(
      .WIDTH (WIDTH)
    ) u_word (
      .clk     (clk),
      .i_rst_n (reset_n),
      .i_we    (w_we[g]),
      .i_d     (wr_data),
      .o_q     (w_word[g])
    );
  end

  always_comb begin
    w_rd_a = '0;
    if (32'(req_addr_a) < DEPTH) begin
      w_rd_a = w_word[req_addr_a];
    end
`ifdef REGFILE_BYPASS_EN
    // Same-edge write wins; w_wr_ok already excludes address 0.
    if (w_wr_ok && (wr_addr == req_addr_a)) begin
      w_rd_a = wr_data;
    end
`endif
  end

  always_comb begin
    w_rd_b = '0;
    if (32'(req_addr_b) < DEPTH) begin
      w_rd_b = w_word[req_addr_b];
    end
`ifdef REGFILE_BYPASS_EN
    if (w_wr_ok && (wr_addr == req_addr_b)) begin
      w_rd_b = wr_data;
    end
`endif
  end

  // A full buffer can refill in the same cycle it drains.
  assign req_ready = (r_state == EMPTY) || rsp_ready;
  assign w_accept  = req_valid && req_ready;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      EMPTY: begin
        if (w_accept) w_state_nxt = FULL;
      end
      FULL: begin
        if (rsp_ready && !w_accept) w_state_nxt = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= EMPTY;
      r_data_a <= '0;
      r_data_b <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_data_a <= w_rd_a;
        r_data_b <= w_rd_b;
      end
    end
  end

  assign rsp_valid  = (r_state == FULL);
  assign rsp_data_a = r_data_a;
  assign rsp_data_b = r_data_b;

endmodule

// File: tb/tb_regfile_read2.sv
// Bench for regfile_read2: directed vector table, async reset sequences
// and random traffic against a behavioural register-file model.
module tb_regfile_read2;

  logic        clk;
  logic        reset_n;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_addr_a;
  logic [4:0]  req_addr_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data_a;
  logic [31:0] rsp_data_b;

  regfile_read2 dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr_a (req_addr_a),
    .req_addr_b (req_addr_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data_a (rsp_data_a),
    .rsp_data_b (rsp_data_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        rv;
    logic [4:0]  aa;
    logic [4:0]  ab;
    logic        rr;
    logic        e_rdy;
    logic        e_vld;
    logic [31:0] e_a;
    logic [31:0] e_b;
  } vec_t;

  int n_pass = 0;
  int n_tot  = 0;

  // Reference model: plain word array plus the held response.
  logic [31:0] m_mem [32];
  bit          m_full;
  logic [31:0] m_a;
  logic [31:0] m_b;

`ifdef REGFILE_BYPASS_EN
  localparam logic [31:0] SAME_EDGE_A = 32'hA5A5A5A5;
`else
  localparam logic [31:0] SAME_EDGE_A = 32'h0;
`endif

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act !== exp) begin
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic vec_t mk(
    input logic we, input logic [4:0] wa,
    input logic [31:0] wd, input logic rv,
    input logic [4:0] aa, input logic [4:0] ab,
    input logic rr, input logic e_rdy,
    input logic e_vld, input logic [31:0] e_a,
    input logic [31:0] e_b);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd;
    v.rv = rv; v.aa = aa; v.ab = ab;
    v.rr = rr; v.e_rdy = e_rdy;
    v.e_vld = e_vld; v.e_a = e_a; v.e_b = e_b;
    return v;
  endfunction

  function automatic logic [31:0] m_read(
    input logic [4:0] ad, input vec_t v);
    if (ad == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (v.we && v.wa == ad) return v.wd;
`endif
    return m_mem[ad];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_mem[i] = '0;
    m_full = 0;
    m_a = '0;
    m_b = '0;
  endtask

  // Called at posedge+1; leaves at next posedge+1.
  task automatic step(input vec_t v, input bit tab);
    bit acc;
    wr_en      = v.we;
    wr_addr    = v.wa;
    wr_data    = v.wd;
    req_valid  = v.rv;
    req_addr_a = v.aa;
    req_addr_b = v.ab;
    rsp_ready  = v.rr;
    #1;
    chk("m_ready", 32'(req_ready), 32'(!m_full || v.rr));
    if (tab) chk("t_ready", 32'(req_ready), 32'(v.e_rdy));
    @(posedge clk);
    acc = v.rv && (!m_full || v.rr);
    if (acc) begin
      m_full = 1;
      m_a = m_read(v.aa, v);
      m_b = m_read(v.ab, v);
    end else if (v.rr) begin
      m_full = 0;
    end
    if (v.we && v.wa != 5'd0) m_mem[v.wa] = v.wd;
    #1;
    chk("m_valid", 32'(rsp_valid), 32'(m_full));
    if (m_full) begin
      chk("m_data_a", rsp_data_a, m_a);
      chk("m_data_b", rsp_data_b, m_b);
    end
    if (tab) begin
      chk("t_valid", 32'(rsp_valid), 32'(v.e_vld));
      if (v.e_vld) begin
        chk("t_data_a", rsp_data_a, v.e_a);
        chk("t_data_b", rsp_data_b, v.e_b);
      end
    end
  endtask

  task automatic idle(input bit rr);
    step(mk(0, 0, 0, 0, 0, 0, rr, 0, 0, 0, 0), 0);
  endtask

  vec_t tbl [15];

  initial begin
    tbl[0]  = mk(0, 0, 0, 1, 3, 0, 1, 1, 1, 0, 0);
    tbl[1]  = mk(1, 7, 32'hDEADBEEF, 0, 0, 0, 1,
                 1, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0, 1, 7, 7, 1, 1, 1,
                 32'hDEADBEEF, 32'hDEADBEEF);
    tbl[3]  = mk(1, 0, 32'h12345678, 0, 0, 0, 1,
                 1, 0, 0, 0);
    tbl[4]  = mk(0, 0, 0, 1, 0, 0, 1, 1, 1, 0, 0);
    tbl[5]  = mk(0, 0, 0, 1, 7, 7, 1, 1, 1,
                 32'hDEADBEEF, 32'hDEADBEEF);
    for (int i = 6; i < 10; i++) begin
      tbl[i] = mk(1, 7, 32'h1, 1, 7, 7, 0, 0, 1,
                  32'hDEADBEEF, 32'hDEADBEEF);
    end
    tbl[10] = mk(0, 0, 0, 1, 7, 7, 1, 1, 1,
                 32'h1, 32'h1);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    tbl[12] = mk(1, 9, 32'hA5A5A5A5, 1, 9, 3, 1,
                 1, 1, SAME_EDGE_A, 0);
    tbl[13] = mk(0, 0, 0, 1, 9, 0, 1, 1, 1,
                 32'hA5A5A5A5, 0);
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);

    reset_n = 0;
    wr_en = 0; wr_addr = 0; wr_data = 0;
    req_valid = 0; req_addr_a = 0; req_addr_b = 0;
    rsp_ready = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(rsp_valid), 0);
    chk("rst_ready", 32'(req_ready), 1);
    chk("rst_data_a", rsp_data_a, 0);
    chk("rst_data_b", rsp_data_b, 0);
    @(negedge clk);
    reset_n = 1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 15; i++) step(tbl[i], 1);

    // Throughput: preload 1..8, then 8 back-to-back reads.
    for (int i = 1; i <= 8; i++) begin
      step(mk(1, 5'(i), 32'h11111111 * i, 0, 0, 0,
              1, 0, 0, 0, 0), 0);
    end
    for (int i = 1; i <= 8; i++) begin
      step(mk(0, 0, 0, 1, 5'(i), 5'(9 - i), 1,
              0, 0, 0, 0), 0);
      chk("tp_valid", 32'(rsp_valid), 1);
      chk("tp_a", rsp_data_a, 32'h11111111 * i);
      chk("tp_b", rsp_data_b, 32'h11111111 * (9 - i));
    end

    // Mid-stream async reset drops the held response.
    step(mk(0, 0, 0, 1, 2, 3, 0, 0, 0, 0, 0), 0);
    #2;
    reset_n = 0;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid), 0);
    chk("mid_rst_a", rsp_data_a, 0);
    chk("mid_rst_b", rsp_data_b, 0);
    m_reset();
    req_valid = 0;
    @(negedge clk);
    reset_n = 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 32; i++) begin
      step(mk(0, 0, 0, 1, 5'(i), 5'(31 - i), 1,
              0, 0, 0, 0), 0);
      chk("post_rst_a", rsp_data_a, 0);
      chk("post_rst_b", rsp_data_b, 0);
    end
    idle(1);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      vec_t v;
      v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      v.we = ($urandom_range(0, 2) != 0);
      v.wa = 5'($urandom_range(0, 31));
      v.wd = $urandom;
      v.rv = ($urandom_range(0, 3) != 0);
      v.aa = 5'($urandom_range(0, 31));
      v.ab = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) v.aa = v.wa;
      if ($urandom_range(0, 3) == 0) v.ab = v.aa;
      v.rr = ($urandom_range(0, 2) != 0);
      step(v, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
